// File: rtl/reg_scoreboard_if.sv
// Issue/write-back/flush bundle of the register scoreboard, plus its status outputs.
// Latency: none (wires only).
// Backpressure: the slave returns iss_stall/iss_fire to the master.
interface reg_scoreboard_if #(
   parameter int NREGS = 32,
   parameter int NSRC  = 3,
   parameter int NDST  = 2
);
   localparam int RIDX_W = $clog2(NREGS);

   logic                     iss_valid;
   logic [NSRC-1:0]          iss_src_vld;
   logic [NSRC*RIDX_W-1:0]   iss_src;
   logic [NDST-1:0]          iss_dst_vld;
   logic [NDST*RIDX_W-1:0]   iss_dst;
   logic                     iss_stall;
   logic                     iss_fire;
   logic [NDST-1:0]          wb_vld;
   logic [NDST*RIDX_W-1:0]   wb_dst;
   logic                     flush;
   logic [NREGS-1:0]         busy_vec;
   logic                     idle;
   logic                     err;

   modport master (
      output iss_valid, iss_src_vld, iss_src, iss_dst_vld, iss_dst, wb_vld, wb_dst, flush,
      input  iss_stall, iss_fire, busy_vec, idle, err
   );

   modport slave (
      input  iss_valid, iss_src_vld, iss_src, iss_dst_vld, iss_dst, wb_vld, wb_dst, flush,
      output iss_stall, iss_fire, busy_vec, idle, err
   );
endinterface

// File: rtl/reg_scoreboard.sv
// RAW/WAW register scoreboard: a pending-writer counter per architectural register.
// Latency: an issue or write-back is visible one edge later; stall is combinational.
// Backpressure: iss_stall blocks issue on flush, a busy source or a saturated destination.
// Optional macro SCOREBOARD_BYPASS_EN lets a source whose last writer retires this cycle issue.
module reg_scoreboard #(
   parameter int NREGS = 32,
   parameter int NSRC  = 3,
   parameter int NDST  = 2,
   parameter int CNT_W = 2
) (
   input  logic          clk,
   input  logic          reset,
   reg_scoreboard_if.slave sb
);
   localparam int RIDX_W = $clog2(NREGS);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NREGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic                        err_q, err_d;
   logic [NREGS-1:0]            busy;
   logic [NREGS-1:0]            inc;
   logic                        hazard;
   logic [RIDX_W-1:0]           src_idx [NSRC];
   logic [RIDX_W-1:0]           dst_idx [NDST];
   logic [RIDX_W-1:0]           wb_idx  [NDST];

   for (genvar k = 0; k < NSRC; k++) begin : g_src
      assign src_idx[k] = sb.iss_src[k*RIDX_W +: RIDX_W];
   end
   for (genvar j = 0; j < NDST; j++) begin : g_dst
      assign dst_idx[j] = sb.iss_dst[j*RIDX_W +: RIDX_W];
      assign wb_idx[j]  = sb.wb_dst[j*RIDX_W +: RIDX_W];
   end
   for (genvar r = 0; r < NREGS; r++) begin : g_busy
      assign busy[r] = |cnt_q[r];
   end

   assign sb.busy_vec  = busy;
   assign sb.idle      = ~|busy;
   assign sb.err       = err_q;
   assign sb.iss_stall = sb.iss_valid && (sb.flush || hazard);
   assign sb.iss_fire  = sb.iss_valid && !sb.iss_stall;

   // Hazard detect from registered counters: RAW on any valid source, or a saturated destination.
   always_comb begin
`ifdef SCOREBOARD_BYPASS_EN
      int nwb;
      nwb = 0;
`endif
      hazard = 1'b0;
      for (int k = 0; k < NSRC; k++) begin
         if (sb.iss_src_vld[k] && busy[src_idx[k]]) begin
`ifdef SCOREBOARD_BYPASS_EN
            // Last writer retiring on exactly one port this cycle releases the source now.
            nwb = 0;
            for (int j = 0; j < NDST; j++) begin
               if (sb.wb_vld[j] && wb_idx[j] == src_idx[k]) nwb++;
            end
            if (!(cnt_q[src_idx[k]] == CNT_W'(1) && nwb == 1)) hazard = 1'b1;
`else
            hazard = 1'b1;
`endif
         end
      end
      for (int j = 0; j < NDST; j++) begin
         if (sb.iss_dst_vld[j] && cnt_q[dst_idx[j]] == CNT_MAX) hazard = 1'b1;
      end
   end

   // Counter update: old + inc - dec in one step, clamping at zero and flagging underflow.
   always_comb begin
      int dec;
      int sum;
      dec   = 0;
      sum   = 0;
      cnt_d = cnt_q;
      err_d = err_q;
      inc   = '0;
      // Duplicate destinations within one issue collapse onto a single bit.
      for (int j = 0; j < NDST; j++) begin
         if (sb.iss_fire && sb.iss_dst_vld[j]) inc[dst_idx[j]] = 1'b1;
      end
      for (int r = 0; r < NREGS; r++) begin
         dec = 0;
         for (int j = 0; j < NDST; j++) begin
            if (sb.wb_vld[j] && wb_idx[j] == RIDX_W'(r)) dec++;
         end
         sum = int'(cnt_q[r]) + int'(inc[r]) - dec;
         if (sum < 0) begin
            cnt_d[r] = '0;
            err_d    = 1'b1;
         end else begin
            cnt_d[r] = CNT_W'(sum);
         end
      end
      // A redirect wipes every pending writer; write-backs that cycle are dropped entirely.
      if (sb.flush) begin
         cnt_d = '0;
         err_d = err_q;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus random traffic vs a counter model.
// Latency: one check pass per clock, sampled mid low phase.
// Backpressure: the model predicts iss_stall/iss_fire each cycle.
module tb_reg_scoreboard;
   localparam int NREGS  = 32;
   localparam int NSRC   = 3;
   localparam int NDST   = 2;
   localparam int CNT_W  = 2;
   localparam int RIDX_W = 5;
   localparam int MAXC   = (1 << CNT_W) - 1;
`ifdef SCOREBOARD_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   reg_scoreboard_if #(.NREGS(NREGS), .NSRC(NSRC), .NDST(NDST)) sb ();

   reg_scoreboard #(.NREGS(NREGS), .NSRC(NSRC), .NDST(NDST), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .sb    (sb)
   );

   int total = 0;
   int bad   = 0;
   int m_cnt [NREGS];
   bit m_err;

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] m_busy_vec();
      logic [63:0] v;
      v = '0;
      for (int r = 0; r < NREGS; r++) v[r] = (m_cnt[r] != 0);
      return v;
   endfunction

   function automatic int fld(logic [NDST*RIDX_W+RIDX_W-1:0] bus, int k);
      return int'(bus[k*RIDX_W +: RIDX_W]);
   endfunction

   function automatic bit m_stall();
      int r;
      int nwb;
      if (!sb.iss_valid) return 1'b0;
      if (sb.flush) return 1'b1;
      for (int k = 0; k < NSRC; k++) begin
         if (sb.iss_src_vld[k]) begin
            r = fld(sb.iss_src, k);
            nwb = 0;
            for (int j = 0; j < NDST; j++)
               if (sb.wb_vld[j] && fld(sb.wb_dst, j) == r) nwb++;
            if (m_cnt[r] != 0 && !(BYP && m_cnt[r] == 1 && nwb == 1)) return 1'b1;
         end
      end
      for (int j = 0; j < NDST; j++)
         if (sb.iss_dst_vld[j] && m_cnt[fld(sb.iss_dst, j)] == MAXC) return 1'b1;
      return 1'b0;
   endfunction

   task automatic m_clear();
      for (int r = 0; r < NREGS; r++) m_cnt[r] = 0;
      m_err = 1'b0;
   endtask

   task automatic set_in(bit iv, logic [2:0] sv, int s0, int s1, int s2,
                         logic [1:0] dv, int d0, int d1, logic [1:0] wv, int w0, int w1, bit fl);
      sb.iss_valid   = iv;
      sb.iss_src_vld = sv;
      sb.iss_src     = {RIDX_W'(s2), RIDX_W'(s1), RIDX_W'(s0)};
      sb.iss_dst_vld = dv;
      sb.iss_dst     = {RIDX_W'(d1), RIDX_W'(d0)};
      sb.wb_vld      = wv;
      sb.wb_dst      = {RIDX_W'(w1), RIDX_W'(w0)};
      sb.flush       = fl;
   endtask

   task automatic idle_in();
      set_in(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0);
   endtask

   // Check outputs against the model, take one clock edge, advance the model.
   task automatic cycle(string tag);
      bit st;
      bit fi;
      bit hit [NREGS];
      int r;
      #1;
      st = m_stall();
      fi = sb.iss_valid && !st;
      check({tag, ".stall"}, 64'(sb.iss_stall), 64'(st));
      check({tag, ".fire"},  64'(sb.iss_fire),  64'(fi));
      check({tag, ".busy"},  64'(sb.busy_vec),  m_busy_vec());
      check({tag, ".idle"},  64'(sb.idle),      64'(m_busy_vec() == 0));
      check({tag, ".err"},   64'(sb.err),       64'(m_err));
      @(posedge clk);
      if (sb.flush) begin
         for (int i = 0; i < NREGS; i++) m_cnt[i] = 0;
      end else begin
         for (int i = 0; i < NREGS; i++) hit[i] = 1'b0;
         if (fi)
            for (int j = 0; j < NDST; j++)
               if (sb.iss_dst_vld[j]) hit[fld(sb.iss_dst, j)] = 1'b1;
         for (int i = 0; i < NREGS; i++) if (hit[i]) m_cnt[i]++;
         for (int j = 0; j < NDST; j++) begin
            if (sb.wb_vld[j]) begin
               r = fld(sb.wb_dst, j);
               if (m_cnt[r] == 0) m_err = 1'b1;
               else m_cnt[r]--;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset(string tag);
      idle_in();
      reset = 1'b1;
      #1;
      check({tag, ".rst_busy"},  64'(sb.busy_vec),  64'd0);
      check({tag, ".rst_idle"},  64'(sb.idle),      64'd1);
      check({tag, ".rst_err"},   64'(sb.err),       64'd0);
      check({tag, ".rst_stall"}, 64'(sb.iss_stall), 64'd0);
      m_clear();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [63:0] v;
      m_clear();
      idle_in();
      reset = 1'b0;
      @(negedge clk);
      do_reset("init");

      // RAW on register 3.
      set_in(1, 3'b000, 0, 0, 0, 2'b01, 3, 0, 2'b00, 0, 0, 0); cycle("raw_iss");
      v = 64'(sb.busy_vec);
      check("raw_busy3", 64'(v[3]), 64'd1);
      set_in(1, 3'b001, 3, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0);
      #1; check("raw_stall", 64'(sb.iss_stall), 64'd1);
      cycle("raw_wait");
      set_in(1, 3'b001, 3, 0, 0, 2'b00, 0, 0, 2'b01, 3, 0, 0);
      #1; check("raw_wbcyc_fire", 64'(sb.iss_fire), 64'(BYP));
      cycle("raw_wb");
      if (!BYP) begin
         set_in(1, 3'b001, 3, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0);
         #1; check("raw_after_fire", 64'(sb.iss_fire), 64'd1);
         cycle("raw_after");
      end

      // RAX/RDX pair.
      set_in(1, 3'b000, 0, 0, 0, 2'b11, 0, 2, 2'b00, 0, 0, 0); cycle("pair_iss");
      check("pair_busy", 64'(sb.busy_vec), 64'h5);
      set_in(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b11, 0, 2, 0); cycle("pair_wb");
      check("pair_clear", 64'(sb.busy_vec), 64'h0);
      check("pair_idle",  64'(sb.idle),     64'd1);

      // Counter saturation on register 5.
      for (int i = 0; i < 3; i++) begin
         set_in(1, 3'b000, 0, 0, 0, 2'b01, 5, 0, 2'b00, 0, 0, 0); cycle("sat_iss");
      end
      set_in(1, 3'b000, 0, 0, 0, 2'b01, 5, 0, 2'b00, 0, 0, 0);
      #1; check("sat_stall", 64'(sb.iss_stall), 64'd1);
      cycle("sat_full");
      set_in(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b01, 5, 0, 0); cycle("sat_wb");
      set_in(1, 3'b000, 0, 0, 0, 2'b01, 5, 0, 2'b00, 0, 0, 0);
      #1; check("sat_fire", 64'(sb.iss_fire), 64'd1);
      cycle("sat_refill");
      set_in(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b11, 5, 5, 0); cycle("sat_drain2");
      set_in(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b01, 5, 0, 0); cycle("sat_drain1");
      check("sat_idle", 64'(sb.idle), 64'd1);

      // Same-edge issue + write-back, then underflow.
      set_in(1, 3'b000, 0, 0, 0, 2'b01, 7, 0, 2'b00, 0, 0, 0); cycle("ovl_iss");
      set_in(1, 3'b000, 0, 0, 0, 2'b01, 7, 0, 2'b01, 7, 0, 0); cycle("ovl_both");
      v = 64'(sb.busy_vec);
      check("ovl_busy7", 64'(v[7]), 64'd1);
      set_in(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b01, 9, 0, 0); cycle("udf_wb");
      v = 64'(sb.busy_vec);
      check("udf_err",   64'(sb.err), 64'd1);
      check("udf_busy9", 64'(v[9]),   64'd0);
      set_in(0, 3'b000, 0, 0, 0, 2'b00, 0, 0, 2'b01, 7, 0, 0); cycle("ovl_drain");

      // Flush with a simultaneous issue, then reset during a flush.
      set_in(1, 3'b000, 0, 0, 0, 2'b11, 1, 4, 2'b00, 0, 0, 0); cycle("fl_fill1");
      set_in(1, 3'b000, 0, 0, 0, 2'b01, 1, 0, 2'b00, 0, 0, 0); cycle("fl_fill2");
      set_in(1, 3'b000, 0, 0, 0, 2'b01, 6, 0, 2'b01, 4, 0, 1);
      #1; check("fl_stall", 64'(sb.iss_stall), 64'd1);
      cycle("fl_edge");
      check("fl_clear", 64'(sb.busy_vec), 64'h0);
      set_in(1, 3'b000, 0, 0, 0, 2'b01, 2, 0, 2'b00, 0, 0, 0); cycle("fl_refill");
      set_in(1, 3'b000, 0, 0, 0, 2'b01, 6, 0, 2'b00, 0, 0, 1);
      #2;
      reset = 1'b1;
      #1;
      check("rst_mid_busy", 64'(sb.busy_vec), 64'h0);
      check("rst_mid_err",  64'(sb.err),      64'd0);
      m_clear();
      @(negedge clk);
      reset = 1'b0;
      idle_in();

      // Random traffic over a small register window to provoke conflicts.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset("rnd");
         end else begin
            set_in($urandom_range(0, 9) < 7, 3'($urandom),
                   $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                   2'($urandom), $urandom_range(0, 7), $urandom_range(0, 7),
                   {$urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3},
                   $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 99) < 3);
            cycle("rnd");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter NREGS, default 32: number of tracked architectural registers.
REQ-002 SHALL have parameter NSRC, default 3: source operands checked per issue.
REQ-003 SHALL have parameter NDST, default 2: destinations per issue and write-back ports. Two covers the RAX+RDX pair.
REQ-004 SHALL have parameter CNT_W, default 2: pending-writer counter width, max 2^CNT_W-1 in flight per register. RIDX_W = $clog2(NREGS), derived.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 iss_valid  in  1  a decoded uop requests issue.
REQ-008 iss_src_vld  in  NSRC  per-source valid.
REQ-009 iss_src  in  NSRC*RIDX_W  source register indices, slot k at [k*RIDX_W +: RIDX_W].
REQ-010 iss_dst_vld  in  NDST  per-destination valid.
REQ-011 iss_dst  in  NDST*RIDX_W  destination register indices.
REQ-012 iss_stall  out  1  issue blocked this cycle (combinational).
REQ-013 iss_fire  out  1  iss_valid && !iss_stall.
REQ-014 wb_vld  in  NDST  per-port write-back completes.
REQ-015 wb_dst  in  NDST*RIDX_W  write-back register indices.
REQ-016 flush  in  1  branch redirect, discards all pending writers.
REQ-017 busy_vec  out  NREGS  bit r = counter[r] != 0.
REQ-018 idle  out  1  all counters zero.
REQ-019 err  out  1  sticky underflow flag.

Function
REQ-020 SHALL keep one CNT_W-bit counter per register, giving the number of issued, not-yet-written-back writers.
REQ-021 iss_stall SHALL be 1 when iss_valid is 1 and any of these holds:
- flush is 1;
- any valid source has a busy register;
- any valid destination counter equals 2^CNT_W-1.
Otherwise iss_stall SHALL be 0. It is 0 whenever iss_valid is 0.
REQ-022 On an edge with iss_fire=1, each distinct valid destination SHALL increment by 1. Duplicate indices within one issue count once.
REQ-023 On each edge, each valid wb port SHALL decrement its register by 1. Duplicate indices across ports decrement once per port.
REQ-024 Same-edge issue and write-back to one register SHALL apply as new = old + inc - dec, in a single update.
REQ-025 A decrement that would take a counter below 0 SHALL leave it at 0 and set err. err stays 1 until reset.
REQ-026 flush=1 SHALL clear all counters at the next edge. Same-cycle issue and write-back are ignored.
REQ-027 Latency: an issue at edge N SHALL show in busy_vec and iss_stall from after edge N. Write-back release follows the same rule except under REQ-031.
REQ-028 WAW issue SHALL be allowed while the counter is below the maximum. WAR needs no tracking.
REQ-029 busy_vec and idle SHALL be decoded from registered counters only.

Reset
REQ-030 reset=1 SHALL asynchronously clear all counters and err. Outputs then read busy_vec=0, idle=1, err=0, iss_stall=0 (with iss_valid=0). This applies mid-operation and overrides flush, issue and write-back.

Configuration
REQ-031 Macro SCOREBOARD_BYPASS_EN, when defined: a source whose register receives a write-back this cycle, with no other pending writer (counter==1 and exactly one wb port naming it), SHALL NOT cause a stall. When undefined, the release becomes visible one cycle after the write-back edge.

Verification
REQ-032 Reset, then issue dst=3 -> busy_vec[3]=1 next cycle. Next issue with src=3 stalls until a wb to 3 occurs; iss_fire follows 1 cycle after the wb edge (or the same cycle with SCOREBOARD_BYPASS_EN).
REQ-033 Issue dst={0,2} (RAX/RDX pair) -> busy_vec=0x5. wb port0=0 and port1=2 on the same edge -> busy_vec=0, idle=1.
REQ-034 Issue dst=5 three times with CNT_W=2 -> counter=3. Fourth issue to dst=5 stalls; one wb to 5 -> the fourth issue fires.
REQ-035 Same edge: counter[7]=1, issue dst=7, wb 7 -> counter[7]=1, busy stays 1. wb to idle register 9 -> err=1, counter stays 0.
REQ-036 Counters {1:2, 4:1}, flush with a simultaneous issue dst=6 -> all counters 0, iss_stall=1 that cycle. Assert reset mid-flush -> immediate busy_vec=0, err=0.
